parking_lot_ctrl: RTL
=====================

# parking_lot_ctrl

Entry-gate controller and occupancy manager for the vehicle parking design. It consumes the one-cycle `car_enter` / `car_exit` pulses produced by the lane car detector and grants entry by opening the gate only when a space is free. It keeps a saturating occupancy count and flags timeouts and irregular events (tailgating, exit at empty). It sits between the detector FSM and the gate actuator / display logic.

## Interface
- `CAPACITY`, default 8: number of parking spaces, ≥1.
- `CNT_W`, default 4: occupancy width; must satisfy 2^CNT_W > CAPACITY.
- `OPEN_CYCLES`, default 32: maximum cycles the gate stays open waiting for a car, ≥2.
- `COOL_CYCLES`, default 4: gate-closing hold-off cycles, ≥1.

Ports:
- `clk` in 1: single clock; all state changes on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `entry_req` in 1: level, a car is waiting at the entry gate (ticket/button).
- `car_enter` in 1: one-cycle pulse, the detector has seen a complete entry.
- `car_exit` in 1: one-cycle pulse, the detector has seen a complete exit.
- `gate_open` out 1: gate actuator command; high only in OPEN.
- `occupancy` out CNT_W: cars currently inside, 0..CAPACITY.
- `full` out 1: `occupancy == CAPACITY`.
- `empty` out 1: `occupancy == 0`.
- `entry_timeout` out 1: one-cycle pulse, gate closed with no car entering.
- `error` out 1: one-cycle pulse on an irregular event (see Operation).

## Operation
- States: IDLE, OPEN, COOLDOWN; 2-bit encoding; one timer of width ≥ clog2(max(OPEN_CYCLES, COOL_CYCLES)+1).
- **IDLE.** `entry_req && !full` → OPEN, timer cleared. Otherwise stay in IDLE.
- **OPEN.**
  - `car_enter` → COOLDOWN.
  - Else, when the timer reaches OPEN_CYCLES-1 → COOLDOWN and pulse `entry_timeout`.
  - Else the timer increments.
- **COOLDOWN.** Counts COOL_CYCLES cycles, then → IDLE. `entry_req` is ignored during COOLDOWN.
- **Occupancy update**, evaluated every cycle and independent of state:
  - `car_enter && !car_exit`: +1, saturating at CAPACITY.
  - `car_exit && !car_enter`: -1, saturating at 0.
  - Both asserted: no change, no error.
- **`error` pulse conditions:**
  - `car_enter` while not in OPEN (tailgate). The count still increments unless already at CAPACITY.
  - `car_enter` at CAPACITY (count held).
  - `car_exit` while empty and without `car_enter` (count held at 0).
- **Registered outputs.** `full`, `empty` and `gate_open` are decoded from registered state/count. `entry_timeout` and `error` are registered pulses.

## Timing
- **Reset values.** State IDLE, timer 0, `occupancy` 0, `gate_open` 0, `full` 0, `empty` 1, `entry_timeout` 0, `error` 0.
- **Request latency.** `entry_req` sampled high at edge N (IDLE, not full) → `gate_open` high in the cycle after edge N.
- **Entry.** `car_enter` sampled at edge M in OPEN → after M, `gate_open` is 0 and `occupancy` is incremented; IDLE is re-entered COOL_CYCLES edges later.
- **Timeout.** With no `car_enter`, `gate_open` stays high for exactly OPEN_CYCLES cycles. `entry_timeout` is high during the first COOLDOWN cycle.
- **Flag latency.** `error` is high the cycle after the offending edge. `full`/`empty` track `occupancy` in the same cycle.
- **Full and pending request.** `entry_req` held while full is not latched. The gate opens the cycle after the first edge where IDLE && !full && `entry_req`, so a `car_exit` freeing a space allows opening one cycle later.
- **Reset mid-operation.** Reset in OPEN drops `gate_open` immediately (asynchronous) and loses the occupancy count.

## Test plan
- **Reset/idle.** Assert reset → all outputs at reset values. Release, no stimulus for 10 cycles → unchanged.
- **Normal entry.** CAPACITY=8. `entry_req`=1 at edge 2 → `gate_open`=1 from cycle 3. `car_enter` at edge 6 → `gate_open`=0, `occupancy`=1, `empty`=0. IDLE after 4 more cycles.
- **Timeout.** `entry_req` pulse, no `car_enter` → `gate_open` high exactly 32 cycles. `entry_timeout` one pulse. `occupancy` unchanged.
- **Fill to capacity.** 8 complete entries → `full`=1. A 9th `entry_req` → `gate_open` stays 0. `car_exit` → `occupancy`=7, `full`=0, gate opens the next cycle with `entry_req` still held.
- **Simultaneous and irregular events.**
  - `car_enter` and `car_exit` in the same cycle at `occupancy`=3 → 3, no error.
  - `car_exit` at 0 → stays 0, `error` pulse.
  - `car_enter` in IDLE at 2 → 3, `error` pulse.
- **Reset mid-OPEN.** Reset asserted while `gate_open`=1 and `occupancy`=5 → `gate_open`=0 and `occupancy`=0 without a clock edge.

Source files
------------

// File: rtl/parking_lot_ctrl.sv
// Entry-gate controller and occupancy manager for the parking lot.
// Opens the gate on request when a space is free and tracks occupancy.
module parking_lot_ctrl #(
    parameter int CAPACITY    = 8,
    parameter int CNT_W       = 4,
    parameter int OPEN_CYCLES = 32,
    parameter int COOL_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             entry_req,
    input  logic             car_enter,
    input  logic             car_exit,
    output logic             gate_open,
    output logic [CNT_W-1:0] occupancy,
    output logic             full,
    output logic             empty,
    output logic             entry_timeout,
    output logic             error
);

    localparam int MAXC = (OPEN_CYCLES > COOL_CYCLES) ? OPEN_CYCLES : COOL_CYCLES;
    localparam int TW   = $clog2(MAXC + 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_OPEN     = 2'd1,
        S_COOLDOWN = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_n;
    logic [TW-1:0]    r_timer;
    logic [TW-1:0]    w_timer_n;
    logic [CNT_W-1:0] r_occ;
    logic [CNT_W-1:0] w_occ_n;
    logic             r_timeout;
    logic             w_timeout_n;
    logic             r_error;
    logic             w_error_n;
    logic             w_full;
    logic             w_empty;

    assign w_full  = (r_occ == CNT_W'(CAPACITY));
    assign w_empty = (r_occ == '0);

    // State, timer, count and pulse registers; reset clears everything.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_timer   <= '0;
            r_occ     <= '0;
            r_timeout <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_timer   <= w_timer_n;
            r_occ     <= w_occ_n;
            r_timeout <= w_timeout_n;
            r_error   <= w_error_n;
        end
    end

    // Gate FSM: open on request, close on entry or timeout, then hold off.
    always_comb begin
        w_state_n   = r_state;
        w_timer_n   = r_timer;
        w_timeout_n = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (entry_req && !w_full) begin
                    w_state_n = S_OPEN;
                    w_timer_n = '0;
                end
            end
            S_OPEN: begin
                if (car_enter) begin
                    w_state_n = S_COOLDOWN;
                    w_timer_n = '0;
                end else if (r_timer == TW'(OPEN_CYCLES - 1)) begin
                    w_state_n   = S_COOLDOWN;
                    w_timer_n   = '0;
                    w_timeout_n = 1'b1;
                end else begin
                    w_timer_n = r_timer + TW'(1);
                end
            end
            S_COOLDOWN: begin
                if (r_timer == TW'(COOL_CYCLES - 1)) begin
                    w_state_n = S_IDLE;
                    w_timer_n = '0;
                end else begin
                    w_timer_n = r_timer + TW'(1);
                end
            end
            default: begin
                w_state_n = S_IDLE;
                w_timer_n = '0;
            end
        endcase
    end

    // Saturating occupancy update and irregular-event detection.
    always_comb begin
        w_occ_n   = r_occ;
        w_error_n = 1'b0;
        if (car_enter && !car_exit) begin
            if (!w_full) begin
                w_occ_n = r_occ + CNT_W'(1);
            end
            if (w_full || (r_state != S_OPEN)) begin
                w_error_n = 1'b1;
            end
        end else if (car_exit && !car_enter) begin
            if (w_empty) begin
                w_error_n = 1'b1;
            end else begin
                w_occ_n = r_occ - CNT_W'(1);
            end
        end
    end

    assign gate_open     = (r_state == S_OPEN);
    assign occupancy     = r_occ;
    assign full          = w_full;
    assign empty         = w_empty;
    assign entry_timeout = r_timeout;
    assign error         = r_error;

endmodule
